// File: rtl/led_bank_scheduler.sv
// Round-robin sharing of a 12-bit LED bank (three nibble slots) between NREQ requesters.
// Each grant holds the bank for DWELL prescaler ticks, unless its requester drops its request early.
module led_bank_scheduler #(
  parameter int NREQ  = 4,
  parameter int DIV_W = 23,
  parameter int DWELL = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [4*NREQ-1:0] pat_i,
  input  logic [2*NREQ-1:0] slot_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic [11:0]       led,
  output logic              busy_o,
  output logic              tick_o
);

  localparam int IW = $clog2(NREQ);
  localparam logic [7:0] DWELL_EFF = (DWELL == 0) ? 8'd1 : 8'(DWELL);

  typedef enum logic [1:0] {IDLE, SHOW, RELEASE} state_t;

  state_t          state, state_nx;
  logic [DIV_W-1:0] div_cnt;
  logic [IW-1:0]   ptr, ptr_nx, idx, idx_nx, win;
  logic            win_found;
  logic [3:0]      pat_q, pat_nx;
  logic [1:0]      slot_q, slot_nx;
  logic [7:0]      dwell_q, dwell_nx;
  logic [NREQ-1:0] gnt_nx, done_nx;
  logic [11:0]     led_nx;

  function automatic logic [11:0] place(input logic [3:0] p, input logic [1:0] s);
    case (s)
      2'd0:    place = {8'h00, p};
      2'd1:    place = {4'h0, p, 4'h0};
      2'd2:    place = {p, 8'h00};
      default: place = {3{p}};
    endcase
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      tick_o  <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick_o  <= &div_cnt;
    end
  end

  // Search starts just after the last served requester, so it is considered last.
  always_comb begin
    int k;
    k         = 0;
    win_found = 1'b0;
    win       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!win_found && req_i[k]) begin
        win_found = 1'b1;
        win       = IW'(k);
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    idx_nx   = idx;
    pat_nx   = pat_q;
    slot_nx  = slot_q;
    dwell_nx = dwell_q;
    gnt_nx   = '0;
    done_nx  = '0;
    led_nx   = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nx = SHOW;
          idx_nx   = win;
          gnt_nx   = NREQ'(1) << win;
          pat_nx   = pat_i[4*win +: 4];
          slot_nx  = slot_i[2*win +: 2];
          dwell_nx = DWELL_EFF;
          led_nx   = place(pat_i[4*win +: 4], slot_i[2*win +: 2]);
        end
      end
      SHOW: begin
        gnt_nx = gnt_o;
        led_nx = led;
        // An abort takes priority over a coincident final tick and never reports done.
        if (!req_i[idx]) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          led_nx   = '0;
          ptr_nx   = idx;
        end else if (tick_o) begin
          if (dwell_q <= 8'd1) begin
            state_nx = RELEASE;
            gnt_nx   = '0;
            led_nx   = '0;
            done_nx  = NREQ'(1) << idx;
            ptr_nx   = idx;
          end else begin
            dwell_nx = dwell_q - 8'd1;
          end
        end
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ptr     <= IW'(NREQ - 1);
      idx     <= '0;
      pat_q   <= '0;
      slot_q  <= '0;
      dwell_q <= '0;
      gnt_o   <= '0;
      done_o  <= '0;
      led     <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      idx     <= idx_nx;
      pat_q   <= pat_nx;
      slot_q  <= slot_nx;
      dwell_q <= dwell_nx;
      gnt_o   <= gnt_nx;
      done_o  <= done_nx;
      led     <= led_nx;
    end
  end

  assign busy_o = (state == SHOW);

endmodule

// File: tb/tb_led_bank_scheduler.sv
// Scoreboard bench for led_bank_scheduler: stimulus queues expected grants/done pulses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_led_bank_scheduler;
  localparam int NREQ = 4, DIV_W = 3, DWELL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] pat = '0;
  logic [7:0]  slot = '0;
  logic [3:0]  gnt, done;
  logic [11:0] led;
  logic        busy, tick;

  led_bank_scheduler #(.NREQ(NREQ), .DIV_W(DIV_W), .DWELL(DWELL)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .pat_i(pat), .slot_i(slot),
    .gnt_o(gnt), .done_o(done), .led(led), .busy_o(busy), .tick_o(tick)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  typedef struct {logic [3:0] g; logic [11:0] l;} gexp_t;
  gexp_t      gq[$];
  logic [3:0] dq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_g(input logic [3:0] g, input logic [11:0] l);
    gexp_t e;
    e.g = g;
    e.l = l;
    gq.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (done != 0) break;
    end
    chk(name, 32'(done != 0), 32'd1);
  endtask

  // Monitor: grant/led/done scoreboard, dwell tick count, RR gap and invariants.
  logic [3:0]  prev_g = '0, prev_d = '0;
  logic [11:0] cur_led = '0;
  int          tcnt = 0, gap = 0;
  bit          rr_phase = 0, seen_g = 0;

  always @(negedge clk) begin
    gexp_t e;
    if (rst) begin
      prev_g = '0; prev_d = '0; tcnt = 0; gap = 0; seen_g = 0;
    end else begin
      chk("invariants", 32'({$onehot0(gnt), $onehot0(done), (gnt != 0) || (led == 0),
                             busy == (gnt != 0)}), 32'hF);
      if (gnt != 0 && prev_g == 0) begin
        if (gq.size() == 0) chk("grant_unexpected", 32'(gnt), 32'd0);
        else begin
          e = gq.pop_front();
          chk("grant_id", 32'(gnt), 32'(e.g));
          chk("grant_led", 32'(led), 32'(e.l));
          cur_led = e.l;
        end
        if (rr_phase && seen_g) chk("rr_gap_le2", 32'(gap <= 2), 32'd1);
        seen_g = 1;
        tcnt = tick ? 1 : 0;
      end else if (gnt != 0) begin
        chk("led_hold", 32'(led), 32'(cur_led));
        if (busy && tick) tcnt++;
      end
      if (gnt == 0) gap++; else gap = 0;
      if (done != 0) begin
        chk("done_one_cycle", 32'(prev_d), 32'd0);
        if (dq.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
        else chk("done_id", 32'(done), 32'(dq.pop_front()));
        chk("dwell_ticks", 32'(tcnt), 32'(DWELL));
      end
      prev_g = gnt;
      prev_d = done;
    end
  end

  initial begin
    int n;
    // Reset hold with random requests
    req = 4'($urandom);
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      req = 4'($urandom);
    end
    req = '0;
    rst = 1'b0;
    for (int t = 0; t < 2; t++) begin
      n = 0;
      while (n < 40) begin
        @(negedge clk);
        n++;
        if (tick) break;
      end
      chk("tick_period", 32'(n), 32'd8);
    end

    // Single request, slot 1; later pattern/slot changes must be ignored
    @(negedge clk);
    req = 4'b0001; pat[3:0] = 4'hA; slot[1:0] = 2'd1;
    push_g(4'b0001, 12'h0A0); dq.push_back(4'b0001);
    @(negedge clk);
    chk("latency_gnt", 32'(gnt), 32'h1);
    chk("latency_led", 32'(led), 32'h0A0);
    pat[3:0] = 4'hF; slot[1:0] = 2'd3;
    wait_done("single_done");
    req = '0;
    @(negedge clk);
    chk("post_done_led", 32'(led), 32'h0);
    chk("post_done_pulse", 32'(done), 32'h0);

    // Replicate, then slot 2
    req = 4'b0001; pat[3:0] = 4'h5; slot[1:0] = 2'd3;
    push_g(4'b0001, 12'h555); dq.push_back(4'b0001);
    wait_done("repl_done");
    req = '0;
    @(negedge clk);
    req = 4'b0100; pat[11:8] = 4'h9; slot[5:4] = 2'd2;
    push_g(4'b0100, 12'h900); dq.push_back(4'b0100);
    wait_done("slot2_done");
    req = '0;
    @(negedge clk);

    // Round robin from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pat = 16'hC321; slot = 8'b11_10_01_00;
    rr_phase = 1;
    push_g(4'b0001, 12'h001); push_g(4'b0010, 12'h020); push_g(4'b0100, 12'h300);
    push_g(4'b1000, 12'hCCC); push_g(4'b0001, 12'h001);
    dq.push_back(4'b0001); dq.push_back(4'b0010); dq.push_back(4'b0100);
    dq.push_back(4'b1000); dq.push_back(4'b0001);
    req = 4'b1111;
    repeat (5) wait_done("rr_done");
    req = '0;
    rr_phase = 0;
    @(negedge clk);

    // Abort requester 1, then 0111 must go to 2
    req = 4'b0010; pat[7:4] = 4'h6; slot[3:2] = 2'd0;
    push_g(4'b0010, 12'h006);
    @(negedge clk);
    chk("abort_granted", 32'(gnt), 32'h2);
    req = '0;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'h0);
    chk("abort_led", 32'(led), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    req = 4'b0111; pat[11:8] = 4'h7; slot[5:4] = 2'd1;
    push_g(4'b0100, 12'h070); dq.push_back(4'b0100);
    @(negedge clk);
    chk("abort_next_gnt", 32'(gnt), 32'h4);
    wait_done("abort_next_done");
    req = '0;
    @(negedge clk);

    // Asynchronous reset in the middle of a SHOW
    req = 4'b0100; pat[11:8] = 4'h3; slot[5:4] = 2'd0;
    push_g(4'b0100, 12'h003);
    @(negedge clk);
    chk("midshow_granted", 32'(gnt), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_led", 32'(led), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    req = 4'b0101; pat[3:0] = 4'h8; slot[1:0] = 2'd1;
    push_g(4'b0001, 12'h080); dq.push_back(4'b0001);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    wait_done("post_rst_done");
    req = '0;
    repeat (2) @(negedge clk);

    chk("gq_empty", 32'(gq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_bank_scheduler.md
Name: led_bank_scheduler

Overview:
Shares the 12-bit LED bank (three 4-bit nibble slots) between NREQ requesters, each of which wants to show a 4-bit pattern. A free-running prescaler generates a slow display tick. A round-robin arbiter grants one requester at a time, and that requester holds the bank for DWELL ticks. The block sits between pattern-producing logic and the top-level led pins, replacing a hard-wired counter-to-LED path.

Parameters:
NREQ, 4, number of requesters (2..8)
DIV_W, 23, prescaler width; one tick every 2^DIV_W clocks
DWELL, 4, ticks per grant (1..255); a value of 0 is treated as 1

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, asynchronous, active-high
req_i  input  NREQ  per-requester request level
pat_i  input  4*NREQ  nibble pattern per requester; requester k uses bits [4k+3:4k]
slot_i  input  2*NREQ  slot select per requester (0..2 = nibble position, 3 = replicate to all three)
gnt_o  output  NREQ  one-hot grant, registered
done_o  output  NREQ  one-cycle pulse when a grant completes its full dwell
led  output  12  LED bank drive, registered
busy_o  output  1  high while state is SHOW
tick_o  output  1  prescaler tick, one-cycle pulse

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high. All flops clear immediately on rst_i, including in the middle of an operation.
- Reset values: gnt_o=0, done_o=0, led=0, busy_o=0, tick_o=0. Prescaler=0, state=IDLE, rr pointer=NREQ-1 (so requester 0 wins first).
- Prescaler: DIV_W-bit counter increments every cycle and wraps. tick_o=1 in the cycle after the counter equals all-ones. Ticks repeat every 2^DIV_W cycles; the first tick occurs 2^DIV_W cycles after reset release.
- FSM states are IDLE, SHOW and RELEASE.
- IDLE:
  - led=0, gnt_o=0.
  - If any req_i is high, select the first set bit searching from pointer+1 modulo NREQ.
  - On the next edge: go to SHOW, set gnt_o one-hot, latch pat_i and slot_i of the winner, load the dwell counter with DWELL.
  - Latency: req_i sampled high in cycle N gives gnt_o and led valid in cycle N+1.
- SHOW:
  - led is driven from the latched pattern: slot 0..2 gives pattern << 4*slot; slot 3 gives {3{pattern}}.
  - pat_i and slot_i changes are ignored.
  - The dwell counter decrements on each tick_o seen while in SHOW. The grant cycle's tick counts only if state is already SHOW.
  - When the DWELL-th tick is seen: go to RELEASE.
  - Abort: if req_i of the granted requester is low in any SHOW cycle, go to IDLE on the next edge. This clears gnt_o and led, sets pointer = granted index and asserts no done_o.
  - If abort and the final tick coincide, abort wins.
- RELEASE (one cycle):
  - gnt_o=0, led=0, done_o[granted]=1, pointer = granted index.
  - Next state is IDLE.
  - A requester that still asserts req_i may be regranted from IDLE, but only after every other pending requester has been served.
- Arbitration fairness: with all requests continuously high, grant order is 0,1,...,NREQ-1,0,...
- busy_o = (state==SHOW).
- Invariants:
  - gnt_o is always zero or one-hot.
  - done_o is always zero or one-hot and only pulses in RELEASE.
  - led=0 whenever gnt_o=0.

Test Plan:
- Reset (DIV_W=3, DWELL=2): hold rst_i with random req_i -> gnt_o=0, done_o=0, led=0x000, tick_o period 8 after release. Assert rst_i asynchronously mid-cycle -> outputs 0 before the next edge.
- Single request: req_i=0001, pat0=0xA, slot0=1 in cycle N -> gnt_o=0001 and led=0x0A0 at N+1. Held until the 2nd tick in SHOW. Then done_o=0001 for exactly one cycle, then led=0x000.
- Replicate and slot 2: pat=0x5, slot=3 -> led=0x555. pat=0x9, slot=2 -> led=0x900.
- Round robin: req_i=1111 held, distinct patterns -> grant sequence 0,1,2,3,0. One done_o pulse each. No grant gap longer than the RELEASE cycle plus the IDLE cycle.
- Abort: grant requester 1, drop req_i[1] before the final tick -> gnt_o=0 and led=0 next cycle, done_o stays 0. With req_i=0111 the next grant goes to 2.
- Reset mid-SHOW: assert rst_i while requester 2 is granted -> gnt_o=0 at once. After release with req_i=0101 -> requester 0 is granted first.
